pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect squashes,
// variable-latency data-memory handshake with timeout watchdog and stall-cycle counter.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_RUN     | normal flow; detects mem op, redirect, load-use each cycle
// S_MEM_WAIT| EX/MEM access outstanding, pipeline frozen until dmem_ack
// S_ERR     | memory timeout; pipeline frozen until reset
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_mem_read,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic        ex_mem_redirect,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_op;
    logic             load_use;

    assign mem_op   = ex_mem_mem_read | ex_mem_mem_write;
    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (reset_n) begin
            case (state)
                S_RUN: begin
                    if (!mem_op) begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        if (ex_mem_redirect) begin
                            // redirect wins over load-use: the dependent instruction is squashed anyway
                            if_id_flush  = 1'b1;
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                        end else if (load_use) begin
                            pc_en       = 1'b0;
                            if_id_en    = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_ack) begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RUN;
            dmem_req  <= 1'b0;
            mem_err   <= 1'b0;
            wait_cnt  <= '0;
            stall_cnt <= 16'd0;
        end else begin
            if ((state != S_ERR) && !pc_en && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            case (state)
                S_RUN: begin
                    if (mem_op) begin
                        state    <= S_MEM_WAIT;
                        dmem_req <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_ack) begin
                        state    <= S_RUN;
                        dmem_req <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= S_ERR;
                        dmem_req <= 1'b0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_ERR;
                    dmem_req <= 1'b0;
                    mem_err  <= 1'b1;
                end
            endcase
        end
    end

endmodule
